// File: rtl/arb_pkg.sv
// arb_pkg: shared types for the 3-way request/grant arbiter and its agents.
package arb_pkg;

  localparam int N_REQ = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    GAP  = 2'd3
  } req_state_e;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_G0   = 2'd1,
    ARB_G1   = 2'd2,
    ARB_G2   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/arb_requester_if.sv
// arb_requester_if: descriptor push, arbiter request/grant and beat bus
// of one requester lane.
interface arb_requester_if #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
) ();

  logic              job_valid;
  logic              job_ready;
  logic [LEN_W-1:0]  job_len;
  logic [DATA_W-1:0] job_data;
  logic              req;
  logic              gnt;
  logic              bus_valid;
  logic [DATA_W-1:0] bus_data;
  logic              bus_last;

  modport master (
    input  job_valid, job_len, job_data, gnt,
    output job_ready, req, bus_valid, bus_data, bus_last
  );

  modport slave (
    output job_valid, job_len, job_data, gnt,
    input  job_ready, req, bus_valid, bus_data, bus_last
  );

endinterface

// File: rtl/arb_req_fifo.sv
// arb_req_fifo: synchronous descriptor queue; head is read in place
// and only advances on pop.
module arb_req_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q;
  logic [AW:0]  rd_q;
  logic         do_push;
  logic         do_pop;

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // extra pointer bit tells full from empty
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign rdata_o = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/arb_requester.sv
// arb_requester: lane agent; queues descriptors, requests, bursts beats.
// Optional grant-wait timeout when ARB_REQ_TIMEOUT_EN is defined.
module arb_requester
  import arb_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int LEN_W      = 4,
  parameter int FIFO_DEPTH = 4
`ifdef ARB_REQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT    = 16
`endif
) (
  input  logic            clk,
  input  logic            resetn,
  arb_requester_if.master bus,
  output logic            busy,
  output logic            timeout_err
);

  localparam int DW = LEN_W + DATA_W;

  req_state_e        state_q, state_d;
  logic              req_q, req_d;
  logic              bvalid_q, bvalid_d;
  logic              blast_q, blast_d;
  logic [DATA_W-1:0] bdata_q, bdata_d;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic              pop;
  logic              full;
  logic              empty;
  logic [DW-1:0]     head;
  logic [LEN_W-1:0]  head_len;
  logic [DATA_W-1:0] head_data;

  assign {head_len, head_data} = head;

  arb_req_fifo #(
    .W     (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (bus.job_valid),
    .pop_i   (pop),
    .wdata_i ({bus.job_len, bus.job_data}),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );

`ifdef ARB_REQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] wait_q, wait_d;
  logic          terr_q, terr_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wait_q <= '0;
      terr_q <= 1'b0;
    end else begin
      wait_q <= wait_d;
      terr_q <= terr_d;
    end
  end

  assign timeout_err = terr_q;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      bvalid_q <= 1'b0;
      blast_q  <= 1'b0;
      bdata_q  <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      bvalid_q <= bvalid_d;
      blast_q  <= blast_d;
      bdata_q  <= bdata_d;
      beat_q   <= beat_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    bvalid_d = 1'b0;
    blast_d  = 1'b0;
    bdata_d  = bdata_q;
    beat_d   = beat_q;
    pop      = 1'b0;
`ifdef ARB_REQ_TIMEOUT_EN
    wait_d   = wait_q;
    terr_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d = REQ;
          req_d   = 1'b1;
          beat_d  = '0;
`ifdef ARB_REQ_TIMEOUT_EN
          wait_d  = '0;
`endif
        end
      end
      REQ: begin
        if (bus.gnt) begin
          bvalid_d = 1'b1;
          bdata_d  = head_data;
          if (head_len == '0) begin
            blast_d = 1'b1;
            req_d   = 1'b0;
            pop     = 1'b1;
            state_d = GAP;
          end else begin
            beat_d  = LEN_W'(1);
            state_d = XFER;
          end
        end else begin
`ifdef ARB_REQ_TIMEOUT_EN
          // this cycle makes TIMEOUT ungranted waits: drop the job
          if (wait_q == TW'(TIMEOUT - 1)) begin
            req_d   = 1'b0;
            pop     = 1'b1;
            terr_d  = 1'b1;
            state_d = GAP;
          end else begin
            wait_d  = wait_q + 1'b1;
          end
`endif
        end
      end
      XFER: begin
        if (bus.gnt) begin
          bvalid_d = 1'b1;
          bdata_d  = head_data + DATA_W'(beat_q);
          if (beat_q == head_len) begin
            blast_d = 1'b1;
            req_d   = 1'b0;
            pop     = 1'b1;
            state_d = GAP;
          end else begin
            beat_d  = beat_q + 1'b1;
          end
        end
      end
      GAP: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.job_ready = ~full;
  assign bus.req       = req_q;
  assign bus.bus_valid = bvalid_q;
  assign bus.bus_data  = bdata_q;
  assign bus.bus_last  = blast_q;
  assign busy          = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_arb_requester.sv
// tb_arb_requester: directed cycle tables for the lane agent,
// acting as local logic and as the arbiter's grant.
module tb_arb_requester;

  logic clk;
  logic resetn;
  logic busy;
  logic terr;
  int   errs;
  int   checks;

  arb_requester_if #(.DATA_W(8), .LEN_W(4)) bus ();

  arb_requester #(
    .DATA_W     (8),
    .LEN_W      (4),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .bus         (bus),
    .busy        (busy),
    .timeout_err (terr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input logic [3:0] l, input logic [7:0] d);
    @(negedge clk);
    bus.job_valid = 1'b1;
    bus.job_len   = l;
    bus.job_data  = d;
  endtask

  task automatic test_reset;
    resetn        = 1'b0;
    bus.job_valid = 1'b0;
    bus.job_len   = '0;
    bus.job_data  = '0;
    bus.gnt       = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.req, bus.bus_valid, bus.bus_last, terr, busy} !== 5'b0) begin
      errs++;
      $display("FAIL reset.flags: got %b want 00000",
               {bus.req, bus.bus_valid, bus.bus_last, terr, busy});
    end
    checks++;
    if (bus.bus_data !== 8'h00) begin
      errs++;
      $display("FAIL reset.data: got %h want 00", bus.bus_data);
    end
    checks++;
    if (bus.job_ready !== 1'b1) begin
      errs++;
      $display("FAIL reset.ready: got %b want 1", bus.job_ready);
    end
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL reset.idle: got req=%b busy=%b want 0 0",
               bus.req, busy);
    end
  endtask

  task automatic test_single;
    bit         er [9] = '{0, 1, 1, 1, 1, 1, 0, 0, 0};
    bit         ev [9] = '{0, 0, 0, 1, 1, 1, 1, 0, 0};
    bit         el [9] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
    bit         eg [9] = '{0, 0, 1, 1, 1, 1, 1, 0, 0};
    logic [7:0] ed [9] = '{8'h00, 8'h00, 8'h00, 8'h10, 8'h11,
                           8'h12, 8'h13, 8'h13, 8'h13};
    push(4'd3, 8'h10);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      bus.job_valid = 1'b0;
      if (i == 0) begin
        checks++;
        if (busy !== 1'b1) begin
          errs++;
          $display("FAIL single.busy: got %b want 1", busy);
        end
      end
      checks++;
      if (bus.req !== er[i]) begin
        errs++;
        $display("FAIL single.req[%0d]: got %b want %b", i, bus.req, er[i]);
      end
      checks++;
      if (bus.bus_valid !== ev[i]) begin
        errs++;
        $display("FAIL single.valid[%0d]: got %b want %b",
                 i, bus.bus_valid, ev[i]);
      end
      checks++;
      if (bus.bus_data !== ed[i]) begin
        errs++;
        $display("FAIL single.data[%0d]: got %h want %h",
                 i, bus.bus_data, ed[i]);
      end
      checks++;
      if (bus.bus_last !== el[i]) begin
        errs++;
        $display("FAIL single.last[%0d]: got %b want %b",
                 i, bus.bus_last, el[i]);
      end
      bus.gnt = eg[i];
    end
    checks++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL single.idle: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_wrap;
    bit         er [9] = '{1, 0, 0, 1, 1, 1, 0, 0, 0};
    bit         ev [9] = '{0, 1, 0, 0, 1, 1, 1, 0, 0};
    bit         el [9] = '{0, 1, 0, 0, 0, 0, 1, 0, 0};
    bit         eg [9] = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
    logic [7:0] ed [9] = '{8'h13, 8'hFF, 8'hFF, 8'hFF, 8'hFE,
                           8'hFF, 8'h00, 8'h00, 8'h00};
    push(4'd0, 8'hFF);
    push(4'd2, 8'hFE);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      bus.job_valid = 1'b0;
      checks++;
      if (bus.req !== er[i]) begin
        errs++;
        $display("FAIL wrap.req[%0d]: got %b want %b", i, bus.req, er[i]);
      end
      checks++;
      if (bus.bus_valid !== ev[i]) begin
        errs++;
        $display("FAIL wrap.valid[%0d]: got %b want %b",
                 i, bus.bus_valid, ev[i]);
      end
      checks++;
      if (bus.bus_data !== ed[i]) begin
        errs++;
        $display("FAIL wrap.data[%0d]: got %h want %h",
                 i, bus.bus_data, ed[i]);
      end
      checks++;
      if (bus.bus_last !== el[i]) begin
        errs++;
        $display("FAIL wrap.last[%0d]: got %b want %b",
                 i, bus.bus_last, el[i]);
      end
      bus.gnt = eg[i];
    end
  endtask

  task automatic test_full;
    bit         er [14] = '{1, 0, 0, 1, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0};
    bit         ev [14] = '{1, 1, 0, 0, 1, 0, 0, 1, 1, 0, 0, 1, 0, 0};
    bit         el [14] = '{0, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0};
    bit         eg [14] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
    logic [7:0] ed [14] = '{8'h20, 8'h21, 8'h21, 8'h21, 8'h30,
                            8'h30, 8'h30, 8'h40, 8'h41, 8'h41,
                            8'h41, 8'h50, 8'h50, 8'h50};
    push(4'd1, 8'h20);
    push(4'd0, 8'h30);
    push(4'd1, 8'h40);
    push(4'd0, 8'h50);
    @(negedge clk);
    checks++;
    if (bus.job_ready !== 1'b0) begin
      errs++;
      $display("FAIL full.ready4: got %b want 0", bus.job_ready);
    end
    bus.job_len  = 4'd0;
    bus.job_data = 8'h99;
    @(negedge clk);
    bus.job_valid = 1'b0;
    checks++;
    if ({bus.job_ready, bus.req, bus.bus_valid} !== 3'b010) begin
      errs++;
      $display("FAIL full.refused: got rdy/req/vld=%b want 010",
               {bus.job_ready, bus.req, bus.bus_valid});
    end
    bus.gnt = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i == 1) begin
        checks++;
        if (bus.job_ready !== 1'b1) begin
          errs++;
          $display("FAIL full.ready_pop: got %b want 1", bus.job_ready);
        end
      end
      checks++;
      if (bus.req !== er[i]) begin
        errs++;
        $display("FAIL full.req[%0d]: got %b want %b", i, bus.req, er[i]);
      end
      checks++;
      if (bus.bus_valid !== ev[i]) begin
        errs++;
        $display("FAIL full.valid[%0d]: got %b want %b",
                 i, bus.bus_valid, ev[i]);
      end
      checks++;
      if (bus.bus_data !== ed[i]) begin
        errs++;
        $display("FAIL full.data[%0d]: got %h want %h",
                 i, bus.bus_data, ed[i]);
      end
      checks++;
      if (bus.bus_last !== el[i]) begin
        errs++;
        $display("FAIL full.last[%0d]: got %b want %b",
                 i, bus.bus_last, el[i]);
      end
      bus.gnt = eg[i];
    end
    checks++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL full.drained: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_stall;
    bit         er [12] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
    bit         ev [12] = '{0, 0, 1, 1, 0, 0, 1, 1, 1, 1, 0, 0};
    bit         el [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    bit         eg [12] = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 0, 0};
    logic [7:0] ed [12] = '{8'h50, 8'h50, 8'h60, 8'h61, 8'h61, 8'h61,
                            8'h62, 8'h63, 8'h64, 8'h65, 8'h65, 8'h65};
    push(4'd5, 8'h60);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bus.job_valid = 1'b0;
      checks++;
      if (bus.req !== er[i]) begin
        errs++;
        $display("FAIL stall.req[%0d]: got %b want %b", i, bus.req, er[i]);
      end
      checks++;
      if (bus.bus_valid !== ev[i]) begin
        errs++;
        $display("FAIL stall.valid[%0d]: got %b want %b",
                 i, bus.bus_valid, ev[i]);
      end
      checks++;
      if (bus.bus_data !== ed[i]) begin
        errs++;
        $display("FAIL stall.data[%0d]: got %h want %h",
                 i, bus.bus_data, ed[i]);
      end
      checks++;
      if (bus.bus_last !== el[i]) begin
        errs++;
        $display("FAIL stall.last[%0d]: got %b want %b",
                 i, bus.bus_last, el[i]);
      end
      bus.gnt = eg[i];
    end
  endtask

`ifdef ARB_REQ_TIMEOUT_EN
  task automatic test_timeout;
    push(4'd0, 8'h70);
    push(4'd0, 8'h71);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.job_valid = 1'b0;
      checks++;
      if ({bus.req, terr, bus.bus_valid} !== 3'b100) begin
        errs++;
        $display("FAIL tmo.wait[%0d]: got req/terr/vld=%b want 100",
                 i, {bus.req, terr, bus.bus_valid});
      end
    end
    @(negedge clk);
    checks++;
    if ({bus.req, terr} !== 2'b01) begin
      errs++;
      $display("FAIL tmo.fire: got req/terr=%b want 01", {bus.req, terr});
    end
    @(negedge clk);
    checks++;
    if ({bus.req, terr} !== 2'b00) begin
      errs++;
      $display("FAIL tmo.gap: got req/terr=%b want 00", {bus.req, terr});
    end
    @(negedge clk);
    checks++;
    if ({bus.req, terr, busy} !== 3'b101) begin
      errs++;
      $display("FAIL tmo.next: got req/terr/busy=%b want 101",
               {bus.req, terr, busy});
    end
    bus.gnt = 1'b1;
    @(negedge clk);
    bus.gnt = 1'b0;
    checks++;
    if ({bus.bus_valid, bus.bus_last, bus.bus_data} !== {2'b11, 8'h71}) begin
      errs++;
      $display("FAIL tmo.beat: got v/l/d=%b%b/%h want 11/71",
               bus.bus_valid, bus.bus_last, bus.bus_data);
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, terr} !== 2'b00) begin
      errs++;
      $display("FAIL tmo.idle: got busy/terr=%b want 00", {busy, terr});
    end
  endtask
`else
  task automatic test_no_timeout;
    push(4'd0, 8'h70);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      bus.job_valid = 1'b0;
      if (i > 0) begin
        checks++;
        if ({bus.req, terr, bus.bus_valid} !== 3'b100) begin
          errs++;
          $display("FAIL notmo.wait[%0d]: got req/terr/vld=%b want 100",
                   i, {bus.req, terr, bus.bus_valid});
        end
      end
    end
    bus.gnt = 1'b1;
    @(negedge clk);
    bus.gnt = 1'b0;
    checks++;
    if ({bus.bus_valid, bus.bus_last, bus.bus_data} !== {2'b11, 8'h70}) begin
      errs++;
      $display("FAIL notmo.beat: got v/l/d=%b%b/%h want 11/70",
               bus.bus_valid, bus.bus_last, bus.bus_data);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL notmo.idle: got busy=%b want 0", busy);
    end
  endtask
`endif

  task automatic test_reset_mid;
    push(4'd7, 8'h80);
    @(negedge clk);
    bus.job_valid = 1'b0;
    bus.gnt       = 1'b1;
    @(negedge clk);
    bus.job_valid = 1'b1;
    bus.job_len   = 4'd0;
    bus.job_data  = 8'hAA;
    repeat (3) @(negedge clk);
    bus.job_valid = 1'b0;
    checks++;
    if ({bus.bus_valid, bus.bus_data} !== {1'b1, 8'h82}) begin
      errs++;
      $display("FAIL rstmid.beat2: got v/d=%b/%h want 1/82",
               bus.bus_valid, bus.bus_data);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if ({bus.req, bus.bus_valid, bus.bus_last, terr, busy} !== 5'b0) begin
      errs++;
      $display("FAIL rstmid.flags: got %b want 00000",
               {bus.req, bus.bus_valid, bus.bus_last, terr, busy});
    end
    checks++;
    if ({bus.job_ready, bus.bus_data} !== {1'b1, 8'h00}) begin
      errs++;
      $display("FAIL rstmid.rdy_data: got %b/%h want 1/00",
               bus.job_ready, bus.bus_data);
    end
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.req, bus.bus_valid, busy} !== 3'b000) begin
        errs++;
        $display("FAIL rstmid.after[%0d]: got req/vld/busy=%b want 000",
                 i, {bus.req, bus.bus_valid, busy});
      end
    end
    bus.gnt = 1'b0;
  endtask

  initial begin
    errs   = 0;
    checks = 0;
    test_reset();
    test_single();
    test_wrap();
    test_full();
    test_stall();
`ifdef ARB_REQ_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
